// File: rtl/cache_line_mem_server.sv
// -----------------------------------------------------------------------------
// cache_line_mem_server
//
// Memory-side responder for data cache refill and writeback traffic. It accepts
// one whole-line request at a time and either streams the line back as a
// wrapped, critical-word-first read burst, or absorbs a line-aligned write
// burst into a word-addressed backing RAM.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset (does not clear RAM contents)
//   req_valid_i  line request valid
//   req_ready_o  request accepted when high together with req_valid_i
//   req_we_i     1 = line write (writeback), 0 = line read (fill)
//   req_addr_i   word address; low bits select the critical word on reads
//   wr_valid_i   write beat valid
//   wr_ready_o   write beat accepted
//   wr_data_i    write beat data
//   wr_done_o    one-cycle pulse after the last write beat is committed
//   rsp_valid_o  read beat valid
//   rsp_ready_i  read beat consumed
//   rsp_data_o   read beat data
//   rsp_last_o   final beat of a read burst
// -----------------------------------------------------------------------------
module cache_line_mem_server #(
   parameter int WORD_WID   = 64,
   parameter int LINE_WORDS = 4,
   parameter int MEM_DEPTH  = 4096,
   parameter int ADDR_WID   = 32,
   parameter int RD_LATENCY = 3
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_we_i,
   input  logic [ADDR_WID-1:0] req_addr_i,
   input  logic                wr_valid_i,
   output logic                wr_ready_o,
   input  logic [WORD_WID-1:0] wr_data_i,
   output logic                wr_done_o,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [WORD_WID-1:0] rsp_data_o,
   output logic                rsp_last_o
);

   localparam int OFF_W  = $clog2(LINE_WORDS);
   localparam int IDX_W  = $clog2(MEM_DEPTH);
   localparam int LINE_W = IDX_W - OFF_W;
   localparam int BEAT_W = OFF_W + 1;
   localparam int LAT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

   localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
   localparam logic [BEAT_W-1:0] BEAT_END  = BEAT_W'(LINE_WORDS);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(LINE_WORDS - 1);
   localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(RD_LATENCY - 1);
   localparam logic [LAT_W-1:0]  LAT_ONE   = LAT_W'(1);
   localparam logic [OFF_W-1:0]  OFF_ONE   = OFF_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      RD_BURST,
      WR_BURST,
      WR_DONE
   } state_e;

   // Request direction is carried by the state itself (RD_* vs WR_*), so no
   // separate write-enable flop is kept.
   state_e              state_q, state_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic [OFF_W-1:0]    off_q, off_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [LAT_W-1:0]    lat_q, lat_d;
   logic                req_ready_q, req_ready_d;
   logic                wr_ready_q, wr_ready_d;
   logic                wr_done_q, wr_done_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_last_q, rsp_last_d;
   logic [WORD_WID-1:0] rsp_data_q, rsp_data_d;

   logic [WORD_WID-1:0] ram_q [MEM_DEPTH];
   logic                ram_we;
   logic [IDX_W-1:0]    wr_idx;
   logic [IDX_W-1:0]    rd_idx;
   logic [WORD_WID-1:0] rd_word;

   // Upper address bits above the RAM index are intentionally ignored, which
   // makes addresses alias modulo MEM_DEPTH.
   logic [LINE_W-1:0]   req_line;
   logic [OFF_W-1:0]    req_off;
   logic                unused_addr;

   assign req_line    = req_addr_i[IDX_W-1:OFF_W];
   assign req_off     = req_addr_i[OFF_W-1:0];
   assign unused_addr = ^req_addr_i;

   // Writes always start at the line base; the latched offset is not used.
   assign wr_idx = {line_q, beat_q[OFF_W-1:0]};
   assign ram_we = (state_q == WR_BURST) && wr_valid_i && wr_ready_q;

   // Read index for the word that will be presented next. The offset sum is
   // OFF_W bits wide so it wraps inside the line, giving the critical-word-first
   // order. In RD_BURST the word being looked up is the one after the beat
   // currently on the bus.
   always_comb begin
      rd_idx = {line_q, off_q};
      if (state_q == IDLE) begin
         rd_idx = {req_line, req_off};
      end else if (state_q == RD_BURST) begin
         rd_idx = {line_q, off_q + beat_q[OFF_W-1:0] + OFF_ONE};
      end
   end

   assign rd_word = ram_q[rd_idx];

   always_comb begin
      state_d     = state_q;
      line_d      = line_q;
      off_d       = off_q;
      beat_d      = beat_q;
      lat_d       = lat_q;
      req_ready_d = req_ready_q;
      wr_ready_d  = wr_ready_q;
      wr_done_d   = 1'b0;
      rsp_valid_d = rsp_valid_q;
      rsp_last_d  = rsp_last_q;
      rsp_data_d  = rsp_data_q;

      case (state_q)
         IDLE: begin
            // req_ready comes up one cycle after reset release or after the
            // previous transaction finishes, since it is a registered output.
            req_ready_d = 1'b1;
            if (req_valid_i && req_ready_q) begin
               req_ready_d = 1'b0;
               line_d      = req_line;
               off_d       = req_off;
               beat_d      = '0;
               if (req_we_i) begin
                  state_d    = WR_BURST;
                  wr_ready_d = 1'b1;
               end else if (RD_LATENCY == 1) begin
                  state_d     = RD_BURST;
                  rsp_valid_d = 1'b1;
                  rsp_last_d  = 1'b0;
                  rsp_data_d  = rd_word;
               end else begin
                  state_d = RD_WAIT;
                  lat_d   = LAT_INIT;
               end
            end
         end

         RD_WAIT: begin
            // Outputs are registered, so the first beat is loaded on the cycle
            // the counter steps to zero; it is then visible RD_LATENCY cycles
            // after acceptance.
            lat_d = lat_q - LAT_ONE;
            if (lat_q == LAT_ONE) begin
               state_d     = RD_BURST;
               rsp_valid_d = 1'b1;
               rsp_last_d  = 1'b0;
               rsp_data_d  = rd_word;
            end
         end

         RD_BURST: begin
            if (rsp_valid_q && rsp_ready_i) begin
               beat_d = beat_q + BEAT_ONE;
               if (beat_d == BEAT_END) begin
                  state_d     = IDLE;
                  rsp_valid_d = 1'b0;
                  rsp_last_d  = 1'b0;
                  rsp_data_d  = '0;
                  req_ready_d = 1'b1;
               end else begin
                  rsp_data_d = rd_word;
                  rsp_last_d = (beat_d == BEAT_LAST);
               end
            end
         end

         WR_BURST: begin
            if (wr_valid_i && wr_ready_q) begin
               beat_d = beat_q + BEAT_ONE;
               if (beat_d == BEAT_END) begin
                  state_d    = WR_DONE;
                  wr_ready_d = 1'b0;
                  wr_done_d  = 1'b1;
               end
            end
         end

         WR_DONE: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         line_q      <= '0;
         off_q       <= '0;
         beat_q      <= '0;
         lat_q       <= '0;
         req_ready_q <= 1'b0;
         wr_ready_q  <= 1'b0;
         wr_done_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_last_q  <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         line_q      <= line_d;
         off_q       <= off_d;
         beat_q      <= beat_d;
         lat_q       <= lat_d;
         req_ready_q <= req_ready_d;
         wr_ready_q  <= wr_ready_d;
         wr_done_q   <= wr_done_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_last_q  <= rsp_last_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   // Backing RAM has no reset; contents survive rst_ni.
   always_ff @(posedge clk_i) begin
      if (ram_we) begin
         ram_q[wr_idx] <= wr_data_i;
      end
   end

   assign req_ready_o = req_ready_q;
   assign wr_ready_o  = wr_ready_q;
   assign wr_done_o   = wr_done_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_last_o  = rsp_last_q;
   assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_cache_line_mem_server.sv
// -----------------------------------------------------------------------------
// tb_cache_line_mem_server
//
// Scoreboard bench for cache_line_mem_server. Drivers issue line requests and
// push the expected read beats (from a word-array model of the RAM) into a
// queue; an independent monitor pops and compares whenever a beat is consumed,
// and also watches first-beat latency and stall stability.
// -----------------------------------------------------------------------------
module tb_cache_line_mem_server;

   localparam int W     = 64;
   localparam int LW    = 4;
   localparam int DEPTH = 4096;
   localparam int AW    = 32;
   localparam int LAT   = 3;

   typedef struct {
      logic [W-1:0] data;
      logic         last;
      int           first_cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready_o;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic          wr_valid = 1'b0;
   logic          wr_ready_o;
   logic [W-1:0]  wr_data = '0;
   logic          wr_done_o;
   logic          rsp_valid_o;
   logic          rsp_ready;
   logic [W-1:0]  rsp_data_o;
   logic          rsp_last_o;

   logic          rand_rdy = 1'b0;
   logic          rnd_rdy = 1'b0;
   logic          rdy_force = 1'b1;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;

   exp_t          exp_q[$];
   logic [W-1:0]  model_mem [DEPTH];
   logic [W-1:0]  wdata [LW];
   logic [AW-1:0] written[$];

   assign rsp_ready = rand_rdy ? rnd_rdy : rdy_force;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   cache_line_mem_server #(
      .WORD_WID   (W),
      .LINE_WORDS (LW),
      .MEM_DEPTH  (DEPTH),
      .ADDR_WID   (AW),
      .RD_LATENCY (LAT)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready_o),
      .req_we_i    (req_we),
      .req_addr_i  (req_addr),
      .wr_valid_i  (wr_valid),
      .wr_ready_o  (wr_ready_o),
      .wr_data_i   (wr_data),
      .wr_done_o   (wr_done_o),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready),
      .rsp_data_o  (rsp_data_o),
      .rsp_last_o  (rsp_last_o)
   );

   // Word index in RAM of beat k for a request at addr: line base plus offset,
   // wrapped within the line for reads, aliased modulo the RAM depth.
   function automatic int beat_index(input logic [AW-1:0] addr, input int k,
                                     input bit from_crit);
      longint unsigned a, base, off, idx;
      a    = addr;
      base = (a / LW) * LW;
      off  = from_crit ? (a % LW) : 0;
      idx  = (base + ((off + k) % LW)) % DEPTH;
      return int'(idx);
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timed_out(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for the DUT (cycle %0d)", name, cyc);
   endtask

   // Drives a request and waits (bounded) for acceptance. Returns with the
   // time at negedge+1 of the acceptance cycle, or ok=0 on timeout.
   task automatic issue_req(input logic [AW-1:0] addr, input logic we, output bit ok);
      int n;
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (!req_ready_o && n < 100);
      ok = req_ready_o;
      if (!ok) begin
         timed_out(we ? "write_req_accept" : "read_req_accept");
         req_valid = 1'b0;
      end
   endtask

   task automatic read_line(input logic [AW-1:0] addr);
      bit ok;
      exp_t e;
      issue_req(addr, 1'b0, ok);
      if (ok) begin
         for (int k = 0; k < LW; k++) begin
            e.data      = model_mem[beat_index(addr, k, 1'b1)];
            e.last      = (k == LW - 1);
            e.first_cyc = (k == 0) ? cyc + LAT : -1;
            exp_q.push_back(e);
         end
         @(posedge clk); #1;
         req_valid = 1'b0;
      end
   endtask

   task automatic wait_q_size(input int sz, input string name);
      int n;
      n = 0;
      while (exp_q.size() > sz && n < 400) begin
         @(negedge clk); #1;
         n++;
      end
      if (exp_q.size() > sz) timed_out(name);
   endtask

   // mode 0: back-to-back beats, 1: fixed 1,0,1,1,0,1 gaps, else random gaps.
   task automatic write_line(input logic [AW-1:0] addr, input int mode);
      bit ok;
      bit v;
      int k, step;
      logic [5:0] pat;
      pat = 6'b101101;
      issue_req(addr, 1'b1, ok);
      if (ok) begin
         @(posedge clk); #1;
         req_valid = 1'b0;
         k = 0;
         step = 0;
         while (k < LW && step < 64) begin
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = pat[step % 6];
            else                v = ($urandom_range(0, 2) != 0);
            wr_valid = v;
            wr_data  = v ? wdata[k] : {$urandom, $urandom};
            @(negedge clk);
            chk("wr_ready_in_burst", wr_ready_o, 1);
            if (v) begin
               model_mem[beat_index(addr, k, 1'b0)] = wdata[k];
               k++;
            end
            step++;
            @(posedge clk); #1;
         end
         if (k < LW) timed_out("write_beats");
         // Extra beats offered after the burst must be ignored.
         wr_valid = 1'b1;
         wr_data  = {$urandom, $urandom};
         @(negedge clk);
         chk("wr_ready_after_last", wr_ready_o, 0);
         chk("wr_done_pulse", wr_done_o, 1);
         chk("req_ready_in_wr_done", req_ready_o, 0);
         @(posedge clk); #1;
         @(negedge clk);
         chk("wr_done_single", wr_done_o, 0);
         chk("req_ready_after_write", req_ready_o, 1);
         chk("wr_ready_idle", wr_ready_o, 0);
         @(posedge clk); #1;
         wr_valid = 1'b0;
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_req_ready"}, req_ready_o, 0);
      chk({tag, "_wr_ready"}, wr_ready_o, 0);
      chk({tag, "_wr_done"}, wr_done_o, 0);
      chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
      chk({tag, "_rsp_last"}, rsp_last_o, 0);
      chk({tag, "_rsp_data"}, rsp_data_o, 0);
   endtask

   // Random ready source for backpressure phases.
   initial begin
      forever begin
         @(posedge clk); #1;
         rnd_rdy = ($urandom_range(0, 1) == 1);
      end
   end

   // Monitor / scoreboard.
   initial begin
      bit prev_valid, prev_stall, prev_last;
      logic [W-1:0] prev_data;
      exp_t e;
      prev_valid = 1'b0;
      prev_stall = 1'b0;
      prev_last  = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         if (!rst_ni) begin
            prev_valid = 1'b0;
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("stall_valid_held", rsp_valid_o, 1);
               chk("stall_data_held", rsp_data_o, prev_data);
               chk("stall_last_held", rsp_last_o, prev_last);
            end
            if (!rsp_valid_o) begin
               chk("idle_rsp_data", rsp_data_o, 0);
               chk("idle_rsp_last", rsp_last_o, 0);
            end
            if (rsp_valid_o && !prev_valid) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_burst: rsp_valid rose with data 0x%0h, no burst expected", rsp_data_o);
               end else if (exp_q[0].first_cyc >= 0) begin
                  chk("first_beat_cycle", 64'(cyc), 64'(exp_q[0].first_cyc));
               end
            end
            if (rsp_valid_o && rsp_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: data 0x%0h consumed, none expected", rsp_data_o);
               end else begin
                  e = exp_q.pop_front();
                  chk("rsp_data", rsp_data_o, e.data);
                  chk("rsp_last", rsp_last_o, e.last);
               end
            end
            prev_stall = rsp_valid_o && !rsp_ready;
            prev_data  = rsp_data_o;
            prev_last  = rsp_last_o;
            prev_valid = rsp_valid_o;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      logic [AW-1:0] a;
      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      @(negedge clk);
      rst_ni = 1'b1;

      // Preload line 8 with back-to-back beats.
      for (int k = 0; k < LW; k++) wdata[k] = 64'hA0 + 64'(k);
      write_line(32'd8, 0);

      // Aligned read, then critical-word-first read.
      read_line(32'd8);
      wait_q_size(0, "read_8_done");
      read_line(32'd10);
      wait_q_size(0, "read_10_done");

      // Stall two cycles on beat 1.
      read_line(32'd8);
      wait_q_size(LW - 1, "stall_beat0");
      @(posedge clk); #1;
      rdy_force = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rdy_force = 1'b1;
      wait_q_size(0, "stall_read_done");

      // Gapped write with aliasing address, then read back through line 8.
      for (int k = 0; k < LW; k++) wdata[k] = 64'hB0 + 64'(k);
      write_line(32'h1008, 1);
      read_line(32'd8);
      wait_q_size(0, "alias_read_done");

      // Asynchronous reset during beat 2 of a read.
      read_line(32'd8);
      wait_q_size(LW - 2, "reset_read_beat1");
      @(posedge clk); #3;
      rst_ni = 1'b0;
      #1;
      check_outputs_zero("async_reset");
      exp_q.delete();
      repeat (2) @(posedge clk);
      #3;
      rst_ni = 1'b1;
      read_line(32'd8);
      wait_q_size(0, "post_reset_read_done");

      // Randomized writes and reads with random backpressure.
      rand_rdy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < LW; k++) wdata[k] = {$urandom, $urandom};
         a = $urandom;
         written.push_back(a);
         write_line(a, 2);
      end
      for (int i = 0; i < 12; i++) begin
         a = written[$urandom_range(0, written.size() - 1)];
         a = a + AW'($urandom_range(0, 7)) * AW'(DEPTH);
         a = (a & ~AW'(LW - 1)) | AW'($urandom_range(0, LW - 1));
         read_line(a);
         wait_q_size(0, "random_read_done");
      end
      rand_rdy = 1'b0;

      repeat (4) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
